// File: rtl/mem_fill_verify_if.sv
// Single-port scratch memory bus: select/address/write data out, registered read data back.
interface mem_fill_verify_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
);
  logic                  mem_select;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_select,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_select,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_fill_verify.sv
// Fill/verify sweep engine for the scratch memory: writes seed+k to every word,
// or reads every word back and counts mismatches against that pattern.
module mem_fill_verify #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] seed,
  mem_fill_verify_if.master     mem,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  start_q;
  logic                  start_edge;
  logic                  accept;
  logic [DATA_WIDTH-1:0] seed_l;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  vld_p1;
  logic                  mismatch_p1;

  // Pattern word for address idx; the sum wraps modulo 2**DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [DATA_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] idx_w;
    idx_w = DATA_WIDTH'(idx);
    return base + idx_w;
  endfunction

  assign start_edge = start & ~start_q;
  assign accept     = start_edge && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_nxt = op ? S_VERIFY : S_FILL;
      S_FILL:         if (addr_p0 == LAST) state_nxt = S_DONE;
      S_VERIFY:       if (addr_p0 == LAST) state_nxt = S_DRAIN;
      S_DRAIN:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_select = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      S_FILL: begin
        mem.mem_select = 1'b1;
        mem.mem_addr   = addr_p0;
        mem.mem_wdata  = pattern(seed_l, addr_p0);
        busy           = 1'b1;
      end
      S_VERIFY: begin
        mem.mem_addr = addr_p0;
        busy         = 1'b1;
      end
      S_DRAIN: begin
        mem.mem_addr = LAST;
        busy         = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    err = (state == S_DONE) && (err_count != '0);
  end

  // Stage p0: sweep address counter; parks at LAST so DRAIN keeps presenting it.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0 <= '0;
    end else if (accept) begin
      addr_p0 <= '0;
    end else if (((state == S_FILL) || (state == S_VERIFY)) && (addr_p0 != LAST)) begin
      addr_p0 <= addr_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk_2) begin
    if (accept) seed_l <= seed;
    addr_p1 <= addr_p0;
  end

  // Stage p1: read data for the address presented last cycle is compared here.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= (state == S_VERIFY);
  end

  assign mismatch_p1 = (mem.mem_rdata != pattern(seed_l, addr_p1));

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (vld_p1 && mismatch_p1) begin
      err_count <= err_count + (ADDR_WIDTH+1)'(1);
      if (err_count == '0) first_err_addr <= addr_p1;
    end
  end

endmodule

// File: tb/tb_mem_fill_verify.sv
// Directed bench for mem_fill_verify: table of fill/verify commands against a
// registered-read memory model, plus reset and start-while-busy sequences.
module tb_mem_fill_verify;

  typedef struct packed {
    logic        op;
    logic [3:0]  seed;
    logic        bd_en;
    logic [1:0]  bd_addr;
    logic [3:0]  bd_val;
    int          exp_busy;
    logic [2:0]  exp_cnt;
    logic [1:0]  exp_first;
    logic [15:0] exp_mem;
  } vec_t;

  logic       clk_2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op    = 1'b0;
  logic [3:0] seed  = 4'h0;
  logic       busy;
  logic       done;
  logic [2:0] err_count;
  logic [1:0] first_err_addr;
  logic       err;

  logic       bd_en   = 1'b0;
  logic [1:0] bd_addr = 2'd0;
  logic [3:0] bd_val  = 4'h0;
  logic [3:0] mem_arr [4];
  int         n_writes = 0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_fill_verify_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) mif ();

  mem_fill_verify #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk_2          (clk_2),
    .rst_n          (rst_n),
    .start          (start),
    .op             (op),
    .seed           (seed),
    .mem            (mif),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .err            (err)
  );

  always #5 clk_2 = ~clk_2;

  // Memory model: write on select, read data registered one cycle after the address.
  always @(posedge clk_2) begin
    if (mif.mem_select) begin
      mem_arr[mif.mem_addr] <= mif.mem_wdata;
      n_writes              <= n_writes + 1;
    end else if (bd_en) begin
      mem_arr[bd_addr] <= bd_val;
    end
    mif.mem_rdata <= mem_arr[mif.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op_i, input logic [3:0] seed_i,
                              input logic bd_i, input logic [1:0] bda_i, input logic [3:0] bdv_i,
                              input int eb_i, input logic [2:0] ec_i, input logic [1:0] ef_i,
                              input logic [15:0] em_i);
    vec_t v;
    v.op = op_i;       v.seed = seed_i;
    v.bd_en = bd_i;    v.bd_addr = bda_i;  v.bd_val = bdv_i;
    v.exp_busy = eb_i; v.exp_cnt = ec_i;   v.exp_first = ef_i;
    v.exp_mem = em_i;
    return v;
  endfunction

  task automatic check_mem(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {mem_arr[3], mem_arr[2], mem_arr[1], mem_arr[0]};
    check(name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          nb;
    logic [15:0] em;
    logic [3:0]  ew;
    string       tag;
    tag   = $sformatf("v%0d", idx);
    em    = v.exp_mem;
    start = 1'b0;
    @(negedge clk_2);
    if (v.bd_en) begin
      bd_en = 1'b1; bd_addr = v.bd_addr; bd_val = v.bd_val;
      @(negedge clk_2);
      bd_en = 1'b0;
    end
    op = v.op; seed = v.seed; start = 1'b1;
    @(negedge clk_2);
    nb = 0;
    while (busy && nb < 20) begin
      if (!v.op) begin
        ew = em[nb[1:0]*4 +: 4];
        check({tag, "_fill_bus"}, {mif.mem_select, mif.mem_addr, mif.mem_wdata},
              {1'b1, nb[1:0], ew});
      end else begin
        check({tag, "_verify_bus"}, {mif.mem_select, mif.mem_addr},
              {1'b0, (nb < 4) ? nb[1:0] : 2'd3});
      end
      nb++;
      @(negedge clk_2);
    end
    check({tag, "_busy_cycles"}, nb, v.exp_busy);
    check({tag, "_done"}, {done, busy, mif.mem_select, mif.mem_addr, mif.mem_wdata}, {1'b1, 1'b0, 1'b0, 2'd0, 4'h0});
    check({tag, "_err_count"}, err_count, v.exp_cnt);
    check({tag, "_first_err"}, first_err_addr, v.exp_first);
    check({tag, "_err"}, err, (v.exp_cnt != 3'd0));
    check_mem({tag, "_mem"}, v.exp_mem);
  endtask

  vec_t vecs [8];

  initial begin
    int w0;
    int nb;

    vecs[0] = mk(1'b0, 4'h3, 1'b0, 2'd0, 4'h0, 4, 3'd0, 2'd0, 16'h6543);
    vecs[1] = mk(1'b1, 4'h3, 1'b0, 2'd0, 4'h0, 5, 3'd0, 2'd0, 16'h6543);
    vecs[2] = mk(1'b1, 4'h3, 1'b1, 2'd2, 4'hF, 5, 3'd1, 2'd2, 16'h6F43);
    vecs[3] = mk(1'b1, 4'h4, 1'b1, 2'd2, 4'h5, 5, 3'd4, 2'd0, 16'h6543);
    vecs[4] = mk(1'b0, 4'hE, 1'b0, 2'd0, 4'h0, 4, 3'd0, 2'd0, 16'h10FE);
    vecs[5] = mk(1'b1, 4'hE, 1'b0, 2'd0, 4'h0, 5, 3'd0, 2'd0, 16'h10FE);
    vecs[6] = mk(1'b1, 4'hE, 1'b1, 2'd3, 4'h0, 5, 3'd1, 2'd3, 16'h00FE);
    vecs[7] = mk(1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 4, 3'd0, 2'd0, 16'h3210);

    // Reset held while start toggles: everything stays at zero, no writes.
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      @(negedge clk_2);
      check("reset_outputs", {busy, done, err, err_count, first_err_addr,
                              mif.mem_select, mif.mem_addr, mif.mem_wdata}, 32'd0);
    end
    check("reset_no_writes", n_writes, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_2);
    @(negedge clk_2);
    check("idle_after_reset", {busy, done, mif.mem_select}, 3'b000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Start re-toggled mid-FILL is ignored and not remembered.
    start = 1'b0;
    @(negedge clk_2);
    w0 = n_writes;
    op = 1'b0; seed = 4'h5; start = 1'b1;
    @(negedge clk_2);
    nb = 0;
    while (busy && nb < 20) begin
      if (nb == 0) start = 1'b0;
      if (nb == 1) start = 1'b1;
      nb++;
      @(negedge clk_2);
    end
    check("busy_start_cycles", nb, 4);
    repeat (3) @(negedge clk_2);
    check("busy_start_no_resweep", {busy, done}, 2'b01);
    check("busy_start_writes", n_writes - w0, 4);
    check_mem("busy_start_mem", 16'h8765);

    // Reset during FILL cycle 1: select drops without a clock edge.
    start = 1'b0;
    @(negedge clk_2);
    w0 = n_writes;
    op = 1'b0; seed = 4'h9; start = 1'b1;
    @(negedge clk_2);
    check("midreset_fill_k0", {mif.mem_select, mif.mem_addr, mif.mem_wdata}, {1'b1, 2'd0, 4'h9});
    @(posedge clk_2);
    #2;
    check("midreset_in_fill_k1", {mif.mem_select, mif.mem_addr}, {1'b1, 2'd1});
    rst_n = 1'b0;
    #1;
    check("midreset_async", {busy, done, mif.mem_select, mif.mem_addr, mif.mem_wdata}, 32'd0);
    @(negedge clk_2);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_2);
    @(negedge clk_2);
    check("midreset_idle", {busy, done, err_count, first_err_addr}, 32'd0);
    check("midreset_writes", n_writes - w0, 1);
    check_mem("midreset_mem", 16'h8769);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
